// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout
// Description : Raster timing generator that scans a luma framebuffer out as
//               grayscale RGB with data-enable, syncs and a frame-start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_scanout #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int RD_LAT   = 1,
    parameter int ADR_BITS = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic [ADR_BITS-1:0] rd_addr_o,
    input  logic [15:0]         rd_d_i,
    output logic                de_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic [23:0]         rgb_o,
    output logic                frame_start_o
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);

    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    typedef struct packed {
        logic fs;
        logic vs;
        logic hs;
        logic act;
    } flags_t;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                w_run;
    logic [c_HW-1:0]     r_hcnt;
    logic [c_VW-1:0]     r_vcnt;
    logic [ADR_BITS-1:0] r_addr;
    logic                w_h_last;
    logic                w_v_last;
    flags_t              w_flags;
    flags_t              r_dly [RD_LAT+1];
    logic [23:0]         r_rgb;
    logic                w_unused_chroma;

    // Run state: the raster starts from the origin one cycle after enable is seen
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (en_i)  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (!en_i) w_state_nxt = c_ST_IDLE;
            default:              w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_run = (r_state == c_ST_RUN);
    end

    assign w_h_last = (r_hcnt == c_H_LAST);
    assign w_v_last = (r_vcnt == c_V_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_run) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_flags     = '0;
        w_flags.act = w_run && (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
        w_flags.hs  = w_run && (r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END);
        w_flags.vs  = w_run && (r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END);
        w_flags.fs  = w_flags.act && (r_hcnt == '0) && (r_vcnt == '0);
    end

    // Linear pixel index tracked incrementally; it points at the pixel being timed now
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            r_addr <= '0;
        end else if (w_run && w_h_last && w_v_last) begin
            r_addr <= '0;
        end else if (w_flags.act) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Flags ride alongside the read so they line up with the returned pixel
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= w_flags;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            r_rgb <= '0;
        end else if (r_dly[RD_LAT-1].act) begin
            r_rgb <= {rd_d_i[7:0], rd_d_i[7:0], rd_d_i[7:0]};
        end else begin
            r_rgb <= '0;
        end
    end

    // Chroma byte is reserved for a future colour path
    assign w_unused_chroma = ^rd_d_i[15:8];

    assign rd_addr_o     = r_addr;
    assign rgb_o         = r_rgb;
    assign de_o          = r_dly[RD_LAT].act;
    assign frame_start_o = r_dly[RD_LAT].fs;
    assign hsync_o       = r_dly[RD_LAT].hs ? HS_POL : ~HS_POL;
    assign vsync_o       = r_dly[RD_LAT].vs ? VS_POL : ~VS_POL;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_scanout
// Description : Directed self-checking bench for fb_scanout (RD_LAT 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  addr1, addr3;
    logic [15:0] d1, d3, p3a, p3b;
    logic        de1, hs1, vs1, fs1;
    logic        de3, hs3, vs3, fs3;
    logic [23:0] rgb1, rgb3;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    fb_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .rd_addr_o(addr1), .rd_d_i(d1),
        .de_o(de1), .hsync_o(hs1), .vsync_o(vs1), .rgb_o(rgb1), .frame_start_o(fs1)
    );

    fb_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(3)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .rd_addr_o(addr3), .rd_d_i(d3),
        .de_o(de3), .hsync_o(hs3), .vsync_o(vs3), .rgb_o(rgb3), .frame_start_o(fs3)
    );

    // Framebuffer models: luma = address, chroma filled with junk
    always @(posedge clk) begin
        d1 <= {8'hA5, 4'h0, addr1};
    end

    always @(posedge clk) begin
        p3a <= {8'h5A, 4'h0, addr3};
        p3b <= p3a;
        d3  <= p3b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at c=0: first cycle with hcnt=vcnt=0 running
    task automatic start();
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        tick(); tick(); tick();
        total++; if (addr1 !== 4'd0)  begin bad++; $display("FAIL reset_addr: got %0d want 0", addr1); end
        total++; if (de1 !== 1'b0)    begin bad++; $display("FAIL reset_de: got %b want 0", de1); end
        total++; if (rgb1 !== 24'h0)  begin bad++; $display("FAIL reset_rgb: got %06h want 000000", rgb1); end
        total++; if (fs1 !== 1'b0)    begin bad++; $display("FAIL reset_fs: got %b want 0", fs1); end
        total++; if (hs1 !== 1'b0)    begin bad++; $display("FAIL reset_hsync: got %b want 0", hs1); end
        total++; if (vs1 !== 1'b0)    begin bad++; $display("FAIL reset_vsync: got %b want 0", vs1); end
        total++; if (de3 !== 1'b0)    begin bad++; $display("FAIL reset_de_lat3: got %b want 0", de3); end
    endtask

    task automatic test_first_line();
        int          exp_addr [16];
        logic [7:0]  exp_luma [16];
        logic [15:0] exp_de;
        logic [23:0] exp_rgb;
        exp_addr = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 5, 6, 7, 8, 8, 8, 8};
        exp_luma = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 4, 5, 6, 7, 0, 0};
        exp_de   = 16'h3C3C;
        start();
        for (int c = 0; c < 16; c++) begin
            exp_rgb = exp_de[c] ? {exp_luma[c], exp_luma[c], exp_luma[c]} : 24'h0;
            total++; if (addr1 !== exp_addr[c][3:0]) begin bad++; $display("FAIL line_addr c=%0d: got %0d want %0d", c, addr1, exp_addr[c]); end
            total++; if (de1 !== exp_de[c]) begin bad++; $display("FAIL line_de c=%0d: got %b want %b", c, de1, exp_de[c]); end
            total++; if (rgb1 !== exp_rgb) begin bad++; $display("FAIL line_rgb c=%0d: got %06h want %06h", c, rgb1, exp_rgb); end
            total++; if (fs1 !== (c == 2)) begin bad++; $display("FAIL line_fs c=%0d: got %b want %b", c, fs1, (c == 2)); end
            tick();
        end
    endtask

    task automatic test_full_frame();
        int n_de0 = 0, n_de1 = 0, n_fs = 0, fs_at0 = -1, fs_at1 = -1;
        start();
        for (int c = 0; c < 98; c++) begin
            if (de1) begin
                if (c < 50) n_de0++; else n_de1++;
            end
            if (fs1) begin
                n_fs++;
                if (c < 50) fs_at0 = c; else fs_at1 = c;
                total++; if (de1 !== 1'b1 || rgb1 !== 24'h0) begin bad++; $display("FAIL fs_align c=%0d: got de=%b rgb=%06h want de=1 rgb=000000", c, de1, rgb1); end
            end
            if (c == 19) begin total++; if (addr1 !== 4'd11) begin bad++; $display("FAIL frame_addr19: got %0d want 11", addr1); end end
            if (c == 27) begin total++; if (addr1 !== 4'd12) begin bad++; $display("FAIL frame_addr27: got %0d want 12", addr1); end end
            if (c == 47) begin total++; if (addr1 !== 4'd12) begin bad++; $display("FAIL frame_addr47: got %0d want 12", addr1); end end
            if (c == 48) begin total++; if (addr1 !== 4'd0)  begin bad++; $display("FAIL frame_addr48: got %0d want 0", addr1); end end
            tick();
        end
        total++; if (n_de0 != 12) begin bad++; $display("FAIL frame0_de_count: got %0d want 12", n_de0); end
        total++; if (n_de1 != 12) begin bad++; $display("FAIL frame1_de_count: got %0d want 12", n_de1); end
        total++; if (n_fs != 2)   begin bad++; $display("FAIL fs_count: got %0d want 2", n_fs); end
        total++; if (fs_at0 != 2) begin bad++; $display("FAIL fs_pos0: got %0d want 2", fs_at0); end
        total++; if (fs_at1 != 50) begin bad++; $display("FAIL fs_pos1: got %0d want 50", fs_at1); end
    endtask

    task automatic test_sync();
        int n_hs = 0, n_vs = 0;
        start();
        for (int c = 0; c < 50; c++) begin
            if (hs1) n_hs++;
            if (vs1) n_vs++;
            if (c == 5) begin total++; if (de1 !== 1'b1) begin bad++; $display("FAIL last_de: got %b want 1", de1); end end
            if (c == 6) begin total++; if (de1 !== 1'b0 || hs1 !== 1'b0) begin bad++; $display("FAIL fp_gap: got de=%b hs=%b want 0 0", de1, hs1); end end
            if (c == 7) begin total++; if (hs1 !== 1'b1) begin bad++; $display("FAIL hs_start: got %b want 1", hs1); end end
            if (c == 8) begin total++; if (hs1 !== 1'b1) begin bad++; $display("FAIL hs_second: got %b want 1", hs1); end end
            if (c == 9) begin total++; if (hs1 !== 1'b0) begin bad++; $display("FAIL hs_end: got %b want 0", hs1); end end
            if (c == 33) begin total++; if (vs1 !== 1'b0) begin bad++; $display("FAIL vs_before: got %b want 0", vs1); end end
            if (c == 34) begin total++; if (vs1 !== 1'b1) begin bad++; $display("FAIL vs_start: got %b want 1", vs1); end end
            if (c == 41) begin total++; if (vs1 !== 1'b1) begin bad++; $display("FAIL vs_last: got %b want 1", vs1); end end
            if (c == 42) begin total++; if (vs1 !== 1'b0) begin bad++; $display("FAIL vs_after: got %b want 0", vs1); end end
            tick();
        end
        total++; if (n_hs != 12) begin bad++; $display("FAIL hs_count: got %0d want 12", n_hs); end
        total++; if (n_vs != 8)  begin bad++; $display("FAIL vs_count: got %0d want 8", n_vs); end
    endtask

    task automatic test_lat3();
        start();
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin total++; if (addr3 !== 4'd0) begin bad++; $display("FAIL lat3_addr0: got %0d want 0", addr3); end end
            if (c == 3) begin total++; if (de3 !== 1'b0) begin bad++; $display("FAIL lat3_de_early: got %b want 0", de3); end end
            if (c == 4) begin
                total++; if (de3 !== 1'b1) begin bad++; $display("FAIL lat3_de_first: got %b want 1", de3); end
                total++; if (fs3 !== 1'b1) begin bad++; $display("FAIL lat3_fs: got %b want 1", fs3); end
                total++; if (rgb3 !== 24'h0) begin bad++; $display("FAIL lat3_rgb0: got %06h want 000000", rgb3); end
            end
            if (c == 5) begin total++; if (rgb3 !== 24'h010101) begin bad++; $display("FAIL lat3_rgb1: got %06h want 010101", rgb3); end end
            if (c == 8) begin total++; if (hs3 !== 1'b0) begin bad++; $display("FAIL lat3_hs_before: got %b want 0", hs3); end end
            if (c == 9) begin total++; if (hs3 !== 1'b1) begin bad++; $display("FAIL lat3_hs_start: got %b want 1", hs3); end end
            if (c == 35) begin total++; if (vs3 !== 1'b0) begin bad++; $display("FAIL lat3_vs_before: got %b want 0", vs3); end end
            if (c == 36) begin total++; if (vs3 !== 1'b1) begin bad++; $display("FAIL lat3_vs_start: got %b want 1", vs3); end end
            tick();
        end
    endtask

    task automatic test_en_abort();
        int k = 0;
        start();
        while (addr1 !== 4'd6 && k < 40) begin
            tick();
            k++;
        end
        total++; if (addr1 !== 4'd6) begin bad++; $display("FAIL abort_wait: got addr %0d want 6 within 40 cycles", addr1); end
        total++; if (de1 !== 1'b1) begin bad++; $display("FAIL abort_midline_de: got %b want 1", de1); end
        en = 1'b0;
        tick();
        total++; if (de1 !== 1'b0)   begin bad++; $display("FAIL abort_de: got %b want 0", de1); end
        total++; if (rgb1 !== 24'h0) begin bad++; $display("FAIL abort_rgb: got %06h want 000000", rgb1); end
        total++; if (fs1 !== 1'b0 || hs1 !== 1'b0 || vs1 !== 1'b0) begin bad++; $display("FAIL abort_flags: got fs=%b hs=%b vs=%b want 0 0 0", fs1, hs1, vs1); end
        total++; if (addr1 !== 4'd0) begin bad++; $display("FAIL abort_addr: got %0d want 0", addr1); end
        total++; if (de3 !== 1'b0)   begin bad++; $display("FAIL abort_de_lat3: got %b want 0", de3); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (addr1 !== 4'd0 || de1 !== 1'b0) begin bad++; $display("FAIL idle_hold i=%0d: got addr=%0d de=%b want 0 0", i, addr1, de1); end
        end
        en = 1'b1;
        tick();
        total++; if (addr1 !== 4'd0) begin bad++; $display("FAIL restart_addr0: got %0d want 0", addr1); end
        tick();
        total++; if (addr1 !== 4'd1) begin bad++; $display("FAIL restart_addr1: got %0d want 1", addr1); end
        tick();
        total++; if (de1 !== 1'b1 || fs1 !== 1'b1) begin bad++; $display("FAIL restart_fs: got de=%b fs=%b want 1 1", de1, fs1); end
        total++; if (rgb1 !== 24'h0) begin bad++; $display("FAIL restart_rgb: got %06h want 000000", rgb1); end
    endtask

    task automatic test_rst_midline();
        start();
        tick(); tick(); tick();
        total++; if (de1 !== 1'b1 || rgb1 !== 24'h010101) begin bad++; $display("FAIL pre_rst_pixel: got de=%b rgb=%06h want 1 010101", de1, rgb1); end
        rst_n = 1'b0;
        tick();
        total++; if (de1 !== 1'b0)   begin bad++; $display("FAIL rst_mid_de: got %b want 0", de1); end
        total++; if (rgb1 !== 24'h0) begin bad++; $display("FAIL rst_mid_rgb: got %06h want 000000", rgb1); end
        total++; if (addr1 !== 4'd0) begin bad++; $display("FAIL rst_mid_addr: got %0d want 0", addr1); end
        total++; if (fs1 !== 1'b0 || hs1 !== 1'b0 || vs1 !== 1'b0) begin bad++; $display("FAIL rst_mid_flags: got fs=%b hs=%b vs=%b want 0 0 0", fs1, hs1, vs1); end
        start();
        for (int i = 0; i < 7; i++) tick();
        total++; if (hs1 !== 1'b1) begin bad++; $display("FAIL pre_rst_hs: got %b want 1", hs1); end
        rst_n = 1'b0;
        tick();
        total++; if (hs1 !== 1'b0) begin bad++; $display("FAIL rst_hs_inactive: got %b want 0", hs1); end
        total++; if (de3 !== 1'b0 || hs3 !== 1'b0) begin bad++; $display("FAIL rst_lat3: got de=%b hs=%b want 0 0", de3, hs3); end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_first_line();
        test_full_frame();
        test_sync();
        test_lat3();
        test_en_abort();
        test_rst_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
